// File: rtl/mem_if_pkg.sv
// Shared definitions for the data-memory port: default widths, request opcodes
// and the access unit's state encoding.
package mem_if_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_INC   = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_e;

endpackage

// File: rtl/mem_access_unit.sv
// Initiator side of the 32 x 8 data-memory port: turns load/store/increment
// requests into single-cycle memory pulses and returns one response each.
module mem_access_unit #(
    parameter int ADDR_W = mem_if_pkg::ADDR_W,
    parameter int DATA_W = mem_if_pkg::DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    // Both request and response sides transfer on the rising edge where
    // valid and ready are high together; a valid side holds its payload
    // stable until that edge.
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_carry,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        dbg_state
);
    import mem_if_pkg::*;

    localparam logic [1:0]        CNT_INIT = 2'(RD_LAT - 1);
    localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_d;
    logic                mem_re_d, mem_we_d;
    logic                resp_valid_d, resp_carry_d, resp_err_d;
    logic [DATA_W-1:0]   resp_data_d;
    logic [DATA_W-1:0]   inc_val;

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        mem_re_d     = 1'b0;
        mem_we_d     = 1'b0;
        resp_valid_d = resp_valid;
        resp_data_d  = resp_data;
        resp_carry_d = resp_carry;
        resp_err_d   = resp_err;
        inc_val      = mem_rdata + ONE;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    case (op_e'(req_op))
                        OP_LOAD, OP_INC: begin
                            mem_addr_d = req_addr;
                            mem_re_d   = 1'b1;
                            cnt_d      = CNT_INIT;
                            op_d       = op_e'(req_op);
                            state_d    = RD;
                        end
                        OP_STORE: begin
                            mem_addr_d  = req_addr;
                            mem_wdata_d = req_wdata;
                            mem_we_d    = 1'b1;
                            resp_data_d = req_wdata;
                            state_d     = WR;
                        end
                        default: begin
                            resp_err_d   = 1'b1;
                            resp_valid_d = 1'b1;
                            state_d      = RESP;
                        end
                    endcase
                end
            end

            RD: begin
                // The first RD edge only retires the read pulse; the latency
                // count starts once the memory has registered the address.
                if (!mem_re) begin
                    if (cnt_q != 2'd0) begin
                        cnt_d = cnt_q - 2'd1;
                    end else if (op_q == OP_INC) begin
                        mem_wdata_d  = inc_val;
                        mem_we_d     = 1'b1;
                        resp_data_d  = inc_val;
                        resp_carry_d = &mem_rdata;
                        state_d      = WR;
                    end else begin
                        resp_data_d  = mem_rdata;
                        resp_valid_d = 1'b1;
                        state_d      = RESP;
                    end
                end
            end

            WR: begin
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end

            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_carry_d = 1'b0;
                    state_d      = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Reset clears the memory strobes asynchronously, so an in-flight write
    // never reaches the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= OP_LOAD;
            cnt_q      <= 2'd0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_carry <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            mem_re     <= mem_re_d;
            mem_we     <= mem_we_d;
            resp_valid <= resp_valid_d;
            resp_data  <= resp_data_d;
            resp_carry <= resp_carry_d;
            resp_err   <= resp_err_d;
        end
    end

endmodule
